// File: rtl/dmem_arbiter.sv
// Purpose: round-robin sequencer sharing the single-port dmem between pipeline port C and loader port L.
// Latency: request sampled in IDLE -> memory access next cycle -> ack/rdata the cycle after (2 cycles).
// Backpressure: requester holds req until its ack; with both ports busy a port waits for at most one other access.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   {c,l}_req/_we/_addr/_wdata/_dsize  per-port request and attributes (dsize = bytes-1, 2 is illegal)
//   {c,l}_ack/_rdata/_err              one-cycle completion pulse with load data and reject flag
//   m_addr/_wData/_writeEnable/_dsize  to dmem, driven only during the access cycle
//   m_rData                            from dmem, combinational on m_addr
//   busy                               high whenever an access is in flight (ACCESS or RESP)
module dmem_arbiter #(
  parameter int unsigned SIZE = 16384
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c_req,
  input  logic        l_req,
  input  logic        c_we,
  input  logic        l_we,
  input  logic [0:31] c_addr,
  input  logic [0:31] l_addr,
  input  logic [0:31] c_wdata,
  input  logic [0:31] l_wdata,
  input  logic [0:1]  c_dsize,
  input  logic [0:1]  l_dsize,
  output logic        c_ack,
  output logic        l_ack,
  output logic [0:31] c_rdata,
  output logic [0:31] l_rdata,
  output logic        c_err,
  output logic        l_err,
  output logic [0:31] m_addr,
  output logic [0:31] m_wData,
  output logic        m_writeEnable,
  output logic [0:1]  m_dsize,
  input  logic [0:31] m_rData,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_e;

  localparam logic [32:0] SIZE_W = 33'(SIZE);

  state_e      state_q, state_d;
  logic        rr_q, rr_d;        // 0 favours C, 1 favours L
  logic        port_q, port_d;    // latched winner: 0 = C, 1 = L
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  dsize_q, dsize_d;

  logic        arb_phase, c_elig, l_elig, grant, win;
  logic        sel_we, sel_err;
  logic [31:0] sel_addr, sel_wdata, rd_aligned;
  logic [1:0]  sel_dsize;
  logic [32:0] sel_end;

  // Arbitration and range check of the candidate winner.
  always_comb begin
    arb_phase = (state_q == IDLE) || (state_q == RESP);
    // The port acked this cycle still shows the req it was just served for.
    c_elig    = arb_phase && c_req && !((state_q == RESP) && !port_q);
    l_elig    = arb_phase && l_req && !((state_q == RESP) && port_q);
    grant     = c_elig || l_elig;
    win       = (c_elig && l_elig) ? rr_q : l_elig;
    sel_we    = win ? l_we    : c_we;
    sel_addr  = win ? l_addr  : c_addr;
    sel_wdata = win ? l_wdata : c_wdata;
    sel_dsize = win ? l_dsize : c_dsize;
    // One bit wider than the address so a wrapping access is seen as out of range.
    sel_end   = {1'b0, sel_addr} + {31'b0, sel_dsize} + 33'd1;
    sel_err   = (sel_dsize == 2'd2) || (sel_end > SIZE_W);
  end

  // dmem returns 4 bytes starting at m_addr, first byte in the MSBs.
  always_comb begin
    rd_aligned = '0;
    case (dsize_q)
      2'd3:    rd_aligned = m_rData;
      2'd1:    rd_aligned = {16'b0, m_rData[0:15]};
      2'd0:    rd_aligned = {24'b0, m_rData[0:7]};
      default: rd_aligned = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dsize_d = dsize_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE, RESP: begin
        if (grant) begin
          state_d = ACCESS;
          rr_d    = ~win;
          port_d  = win;
          we_d    = sel_we;
          err_d   = sel_err;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          dsize_d = sel_dsize;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rdata_d = (we_q || err_q) ? 32'b0 : rd_aligned;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      dsize_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dsize_q <= dsize_d;
      rdata_q <= rdata_d;
    end
  end

  // All outputs decode from reset-cleared state, so reset silences them without a clock.
  always_comb begin
    busy          = (state_q != IDLE);
    m_addr        = (state_q == ACCESS) ? addr_q  : '0;
    m_wData       = (state_q == ACCESS) ? wdata_q : '0;
    m_dsize       = (state_q == ACCESS) ? dsize_q : '0;
    m_writeEnable = (state_q == ACCESS) && we_q && !err_q;
    c_ack         = (state_q == RESP) && !port_q;
    l_ack         = (state_q == RESP) && port_q;
    c_rdata       = c_ack ? rdata_q : '0;
    l_rdata       = l_ack ? rdata_q : '0;
    c_err         = c_ack && err_q;
    l_err         = l_ack && err_q;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
  localparam int SIZE = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_req = 1'b0, l_req = 1'b0, c_we = 1'b0, l_we = 1'b0;
  logic [31:0] c_addr = '0, l_addr = '0, c_wdata = '0, l_wdata = '0;
  logic [1:0]  c_dsize = '0, l_dsize = '0;
  logic        c_ack, l_ack, c_err, l_err, m_writeEnable, busy;
  logic [31:0] c_rdata, l_rdata, m_addr, m_wData, m_rData;
  logic [1:0]  m_dsize;

  dmem_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .l_req(l_req), .c_we(c_we), .l_we(l_we),
    .c_addr(c_addr), .l_addr(l_addr), .c_wdata(c_wdata), .l_wdata(l_wdata),
    .c_dsize(c_dsize), .l_dsize(l_dsize),
    .c_ack(c_ack), .l_ack(l_ack), .c_rdata(c_rdata), .l_rdata(l_rdata),
    .c_err(c_err), .l_err(l_err),
    .m_addr(m_addr), .m_wData(m_wData), .m_writeEnable(m_writeEnable),
    .m_dsize(m_dsize), .m_rData(m_rData), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- dmem model (big-endian byte array) ----------------
  bit [7:0]    dmem [SIZE];
  logic [31:0] rd_word;
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < 4; i++)
      if (({1'b0, m_addr} + 33'(i)) < 33'(SIZE))
        rd_word[31 - 8 * i -: 8] = dmem[m_addr + 32'(i)];
  end
  assign m_rData = rd_word;

  always @(posedge clk) begin
    if (m_writeEnable)
      for (int i = 0; i < 4; i++)
        if (i <= int'(m_dsize) && ({1'b0, m_addr} + 33'(i)) < 33'(SIZE))
          dmem[m_addr + 32'(i)] <= 8'(m_wData >> (8 * (int'(m_dsize) - i)));
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  dsize;
    int          gap;
  } stim_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          we_pulses;
    int          issue_cyc;
    int          max_lat;
    int          exact_lat;
  } exp_t;

  typedef struct {
    int port;
    int cyc;
  } log_t;

  bit [7:0] ref_mem [SIZE];
  stim_t    stim_c[$], stim_l[$];
  exp_t     exp_c[$], exp_l[$];
  log_t     ack_log[$];
  int       total = 0, bad = 0;
  int       we_cnt = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Memory as a byte array, accesses as byte runs, range check in plain integers.
  function automatic exp_t model(stim_t s);
    exp_t   e;
    int     n = int'(s.dsize) + 1;
    longint last_excl = longint'(s.addr) + longint'(n);
    e.err       = (s.dsize == 2'd2) || (last_excl > longint'(SIZE));
    e.rdata     = '0;
    e.we_pulses = 0;
    e.issue_cyc = 0;
    e.max_lat   = 0;
    e.exact_lat = 0;
    if (!e.err) begin
      if (s.we) begin
        e.we_pulses = 1;
        for (int i = 0; i < n; i++) ref_mem[s.addr + 32'(i)] = 8'(s.wdata >> (8 * (n - 1 - i)));
      end else begin
        for (int i = 0; i < n; i++) e.rdata = (e.rdata << 8) | 32'(ref_mem[s.addr + 32'(i)]);
      end
    end
    return e;
  endfunction

  function automatic stim_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [1:0] dsize, int gap);
    stim_t s;
    s.we = we; s.addr = addr; s.wdata = wdata; s.dsize = dsize; s.gap = gap;
    return s;
  endfunction

  // Each port works its own address window so expectations never depend on arbitration order.
  function automatic stim_t rand_stim(int p, int gapmax);
    stim_t s;
    s.we    = 1'($urandom_range(0, 1));
    s.dsize = 2'($urandom_range(0, 3));
    s.wdata = $urandom;
    s.gap   = int'($urandom_range(0, gapmax));
    if ($urandom_range(0, 7) == 0) s.addr = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    else if (p == 0)               s.addr = 32'h100 + 32'($urandom_range(0, 31));
    else                           s.addr = 32'(SIZE - 32) + 32'($urandom_range(0, 31));
    return s;
  endfunction

  function automatic void mon_port(int p, logic [31:0] rdata, logic err);
    exp_t  e;
    string pre = (p == 0) ? "c_" : "l_";
    int    qsz = (p == 0) ? exp_c.size() : exp_l.size();
    int    lat;
    chk({pre, "ack_expected"}, 32'(qsz), 32'd1);
    if (qsz == 0) return;
    e   = (p == 0) ? exp_c.pop_front() : exp_l.pop_front();
    lat = cyc - e.issue_cyc;
    chk({pre, "rdata"}, rdata, e.rdata);
    chk({pre, "err"}, 32'(err), 32'(e.err));
    chk({pre, "write_pulses"}, 32'(we_cnt), 32'(e.we_pulses));
    if (e.exact_lat > 0) chk({pre, "latency"}, 32'(lat), 32'(e.exact_lat));
    else                 chk({pre, "latency_bound"}, 32'(lat <= e.max_lat), 32'd1);
    ack_log.push_back('{port: p, cyc: cyc});
  endfunction

  // Monitor: every ack is matched against the front of that port's expectation queue.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      we_cnt = 0;
    end else begin
      if (m_writeEnable) we_cnt++;
      if (c_ack || l_ack) chk("dual_ack", 32'(c_ack && l_ack), 32'd0);
      if (c_ack) mon_port(0, c_rdata, c_err);
      if (l_ack) mon_port(1, l_rdata, l_err);
      if (c_ack || l_ack) we_cnt = 0;
    end
  end

  // ---------------- drivers ----------------
  task automatic issue(input int p, input stim_t s, input bit gap0, input bit exact);
    exp_t e;
    e = model(s);
    e.issue_cyc = cyc;
    e.max_lat   = gap0 ? 5 : 4;
    e.exact_lat = exact ? 2 : 0;
    if (p == 0) begin
      c_req = 1'b1; c_we = s.we; c_addr = s.addr; c_wdata = s.wdata; c_dsize = s.dsize;
      exp_c.push_back(e);
    end else begin
      l_req = 1'b1; l_we = s.we; l_addr = s.addr; l_wdata = s.wdata; l_dsize = s.dsize;
      exp_l.push_back(e);
    end
  endtask

  function automatic bit has_stim(int p);
    return (p == 0) ? (stim_c.size() != 0) : (stim_l.size() != 0);
  endfunction

  function automatic int peek_gap(int p);
    return (p == 0) ? stim_c[0].gap : stim_l[0].gap;
  endfunction

  function automatic stim_t pop_stim(int p);
    if (p == 0) return stim_c.pop_front();
    return stim_l.pop_front();
  endfunction

  task automatic drop_req(input int p);
    if (p == 0) c_req = 1'b0;
    else        l_req = 1'b0;
  endtask

  // Plays both stimulus queues; a gap of 0 re-requests in the ack cycle itself.
  task automatic run_engine(input bit exact);
    int    cnt [2];
    bit    act [2];
    bit    done;
    bit    ackp;
    stim_t s;
    cnt[0] = 1; cnt[1] = 1; act[0] = 1'b0; act[1] = 1'b0; done = 1'b0;
    for (int guard = 0; guard < 4000 && !done; guard++) begin
      @(negedge clk);
      for (int p = 0; p < 2; p++) begin
        ackp = (p == 0) ? c_ack : l_ack;
        if (act[p] && ackp) begin
          act[p] = 1'b0;
          if (has_stim(p) && peek_gap(p) == 0) begin
            s = pop_stim(p);
            issue(p, s, 1'b1, exact);
            act[p] = 1'b1;
          end else begin
            drop_req(p);
            if (has_stim(p)) cnt[p] = peek_gap(p);
          end
        end else if (!act[p] && has_stim(p)) begin
          if (cnt[p] <= 1) begin
            s = pop_stim(p);
            issue(p, s, 1'b0, exact);
            act[p] = 1'b1;
          end else begin
            cnt[p]--;
          end
        end
      end
      if (!act[0] && !act[1] && !has_stim(0) && !has_stim(1)) done = 1'b1;
    end
    chk("engine_done", 32'(done), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    bit    got;
    int    log_start, n;

    // Reset held with C requesting: everything silent.
    s = mk(1'b0, 32'h0, 32'h0, 2'd3, 0);
    c_req = 1'b1; c_we = s.we; c_addr = s.addr; c_dsize = s.dsize;
    repeat (3) @(negedge clk);
    chk("rst_c_ack", 32'(c_ack), 32'd0);
    chk("rst_l_ack", 32'(l_ack), 32'd0);
    chk("rst_c_err", 32'(c_err), 32'd0);
    chk("rst_c_rdata", c_rdata, 32'd0);
    chk("rst_m_we", 32'(m_writeEnable), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_dsize", 32'(m_dsize), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    issue(0, s, 1'b0, 1'b1);
    rst_n = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (c_ack) got = 1'b1;
    end
    c_req = 1'b0;
    chk("reset_release_ack", 32'(got), 32'd1);

    // Directed single-port traffic: sizes, alignment, error cases.
    stim_c.push_back(mk(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd3, 2));
    stim_c.push_back(mk(1'b0, 32'h100, 32'h0, 2'd3, 2));
    stim_c.push_back(mk(1'b1, 32'h203, 32'h0000_00AB, 2'd0, 2));
    stim_c.push_back(mk(1'b1, 32'h200, 32'h0000_1234, 2'd1, 2));
    stim_c.push_back(mk(1'b0, 32'h203, 32'h0, 2'd0, 2));
    stim_c.push_back(mk(1'b0, 32'h200, 32'h0, 2'd1, 2));
    stim_c.push_back(mk(1'b0, 32'h200, 32'h0, 2'd3, 2));
    stim_c.push_back(mk(1'b1, 32'h10, 32'hFFFF_FFFF, 2'd2, 2));
    stim_c.push_back(mk(1'b0, 32'h10, 32'h0, 2'd3, 2));
    stim_c.push_back(mk(1'b0, 32'(SIZE - 2), 32'h0, 2'd3, 2));
    stim_c.push_back(mk(1'b0, 32'hFFFF_FFFE, 32'h0, 2'd3, 2));
    stim_c.push_back(mk(1'b1, 32'(SIZE - 4), 32'hCAFE_F00D, 2'd3, 2));
    stim_c.push_back(mk(1'b0, 32'(SIZE - 4), 32'h0, 2'd3, 2));
    stim_c.push_back(mk(1'b1, 32'h40, 32'h1122_3344, 2'd3, 2));
    run_engine(1'b1);

    // Reset in the middle of a store: the write must not land and no ack follows.
    @(negedge clk);
    c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'h5566_7788; c_dsize = 2'd3;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (m_writeEnable) got = 1'b1;
    end
    chk("midstore_reached_access", 32'(got), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midstore_m_we", 32'(m_writeEnable), 32'd0);
    chk("midstore_busy", 32'(busy), 32'd0);
    chk("midstore_c_ack", 32'(c_ack), 32'd0);
    chk("midstore_m_addr", m_addr, 32'd0);
    c_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Both ports continuously requesting from reset: strict alternation starting with C.
    for (int i = 0; i < 6; i++) begin
      stim_c.push_back(rand_stim(0, 0));
      stim_l.push_back(rand_stim(1, 0));
    end
    log_start = ack_log.size();
    run_engine(1'b0);
    n = ack_log.size() - log_start;
    chk("contention_acks", 32'(n), 32'd12);
    for (int k = 0; k < n; k++) begin
      chk("contention_port", 32'(ack_log[log_start + k].port), 32'(k % 2));
      if (k > 0)
        chk("contention_spacing", 32'(ack_log[log_start + k].cyc - ack_log[log_start + k - 1].cyc), 32'd2);
    end

    // The interrupted store left the old word in place.
    stim_c.push_back(mk(1'b0, 32'h40, 32'h0, 2'd3, 1));
    run_engine(1'b1);

    // Random mixed traffic on both ports.
    for (int i = 0; i < 40; i++) begin
      stim_c.push_back(rand_stim(0, 3));
      stim_l.push_back(rand_stim(1, 3));
    end
    run_engine(1'b0);

    repeat (3) @(negedge clk);
    chk("leftover_c", 32'(exp_c.size()), 32'd0);
    chk("leftover_l", 32'(exp_l.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
